bitwise_op_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle bitwise AND primitive used in the HPF test chain.
- Applies a runtime-selectable bitwise operation (AND/OR/XOR/AND-NOT) to CHANNELS independent WIDTH-bit lanes.
- Uses a valid/ready elastic pipeline of DEPTH stages, with per-channel enables and zero-result flags.
- Sits between sample sources (amplifier or DAC data paths) and downstream consumers that may stall.

---
 rtl/bitwise_op_pipe.sv | 119 +++++++++++
 tb/tb_bitwise_op_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_op_pipe.sv
// Elastic DEPTH-stage pipeline that applies AND/OR/XOR/AND-NOT to CHANNELS
// independent WIDTH-bit lanes. Each result carries per-lane zero flags.
module bitwise_op_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [1:0]                op,
  input  logic [CHANNELS-1:0]       ch_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       zero_flags,
  output logic [15:0]               xfer_count
);

  localparam int DW = CHANNELS * WIDTH;

  // Handshake rule: an item moves across a boundary on a clock edge only when
  // the sender's valid and the receiver's ready are both high in that cycle.
  // valid never depends on ready; ready may depend combinationally on
  // downstream ready.

  logic [DW-1:0]       data_q [DEPTH];
  logic [DW-1:0]       data_d [DEPTH];
  logic [CHANNELS-1:0] zf_q   [DEPTH];
  logic [CHANNELS-1:0] zf_d   [DEPTH];
  logic [DEPTH-1:0]    v_q, v_d;
  logic [DEPTH-1:0]    load, move;
  logic [15:0]         xfer_count_q, xfer_count_d;
  logic [DW-1:0]       raw, res;
  logic [CHANNELS-1:0] res_zf;

  always_comb begin
    raw    = '0;
    res    = '0;
    res_zf = '0;
    case (op)
      2'b00:   raw = a & b;
      2'b01:   raw = a | b;
      2'b10:   raw = a ^ b;
      default: raw = a & ~b;
    endcase
    for (int k = 0; k < CHANNELS; k++) begin
      res[k*WIDTH +: WIDTH] = ch_en[k] ? raw[k*WIDTH +: WIDTH] : '0;
      res_zf[k]             = (res[k*WIDTH +: WIDTH] == '0);
    end
  end

  // Ready ripples from the output back to stage 0 so a full pipeline that is
  // draining can still accept a new item in the same cycle.
  always_comb begin
    move            = '0;
    load            = '0;
    move[DEPTH-1]   = v_q[DEPTH-1] && out_ready;
    load[DEPTH-1]   = !v_q[DEPTH-1] || move[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      move[i] = v_q[i] && load[i+1];
      load[i] = !v_q[i] || move[i];
    end
  end

  always_comb begin
    v_d          = v_q;
    data_d       = data_q;
    zf_d         = zf_q;
    xfer_count_d = xfer_count_q;
    if (load[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = res;
        zf_d[0]   = res_zf;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          data_d[i] = data_q[i-1];
          zf_d[i]   = zf_q[i-1];
        end
      end
    end
    if (move[DEPTH-1] && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q          <= '0;
      xfer_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        zf_q[i]   <= '0;
      end
    end else begin
      v_q          <= v_d;
      xfer_count_q <= xfer_count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        zf_q[i]   <= zf_d[i];
      end
    end
  end

  assign in_ready   = load[0];
  assign out_valid  = v_q[DEPTH-1];
  assign out        = data_q[DEPTH-1];
  assign zero_flags = zf_q[DEPTH-1];
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_bitwise_op_pipe.sv
// Randomized and directed checks of bitwise_op_pipe against a truth-table
// reference model with an in-order expected-result queue.
module tb_bitwise_op_pipe;

  localparam int W  = 4;
  localparam int C  = 3;
  localparam int D  = 3;
  localparam int DW = W * C;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] a, b;
  logic [1:0]    op;
  logic [C-1:0]  ch_en;
  logic          out_valid, out_ready;
  logic [DW-1:0] out;
  logic [C-1:0]  zero_flags;
  logic [15:0]   xfer_count;

  logic [C+DW-1:0] exp_q[$];
  logic [C+DW-1:0] e;
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  bit done     = 1'b0;

  bitwise_op_pipe #(.WIDTH(W), .CHANNELS(C), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .ch_en(ch_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero_flags(zero_flags), .xfer_count(xfer_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: per-bit truth table indexed by {a_bit, b_bit}.
  function automatic logic [C+DW-1:0] model(input logic [DW-1:0] ai, input logic [DW-1:0] bi,
                                            input logic [1:0] o, input logic [C-1:0] en);
    logic [3:0]    tt [4];
    logic [3:0]    sel;
    logic [DW-1:0] r;
    logic [C-1:0]  z;
    tt[0] = 4'b1000;
    tt[1] = 4'b1110;
    tt[2] = 4'b0110;
    tt[3] = 4'b0100;
    sel = tt[o];
    r = '0;
    z = '0;
    for (int k = 0; k < C; k++) begin
      int ones;
      ones = 0;
      for (int j = 0; j < W; j++) begin
        int idx;
        idx = k * W + j;
        r[idx] = en[k] ? sel[{ai[idx], bi[idx]}] : 1'b0;
        ones += int'(r[idx]);
      end
      z[k] = (ones == 0);
    end
    return {z, r};
  endfunction

  // scoreboard: handshakes are judged at the negedge preceding their edge
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out", 32'(out), 32'(e[DW-1:0]));
          check("zero_flags", 32'(zero_flags), 32'(e[C+DW-1:DW]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, op, ch_en));
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] ai, input logic [DW-1:0] bi,
                      input logic [1:0] o, input logic [C-1:0] en);
    int n;
    in_valid = 1'b1;
    a = ai;
    b = bi;
    op = o;
    ch_en = en;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)), C'($urandom));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] pa [5];
  logic [W-1:0] pb [5];
  logic [W-1:0] lane_a, lane_b;
  logic [DW-1:0] hold_exp;
  int lat;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = 2'b00;
    ch_en = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_zero_flags", 32'(zero_flags), 32'd0);
    check("rst_xfer_count", 32'(xfer_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    // latency with out_ready held high
    out_ready = 1'b1;
    send({C{4'hF}}, {C{4'h6}}, 2'b00, '1);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", 32'(lat), 32'(D));
    wait_drain();

    // back-to-back AND sequence, then op sweep, then lane enables
    pa = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
    pb = '{4'h0, 4'h5, 4'hF, 4'h0, 4'hA};
    for (int i = 0; i < 5; i++) begin
      lane_a = pa[i];
      lane_b = pb[i];
      send({C{lane_a}}, {C{lane_b}}, 2'b00, '1);
    end
    for (int o = 0; o < 4; o++) send({C{4'b0011}}, {C{4'b0101}}, 2'(o), '1);
    send('1, '1, 2'b00, C'(1));
    send('1, '0, 2'b11, C'(5));
    wait_drain();
    check("xfer_after_directed", 32'(xfer_count), 32'(n_out));

    // stall: fill, then offer one more while full
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) send_rand();
    hold_exp = exp_q[0][DW-1:0];
    in_valid = 1'b1;
    a = DW'($urandom);
    b = DW'($urandom);
    op = 2'b10;
    ch_en = '1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_hold", 32'(out), 32'(hold_exp));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("full_pass_through_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      check("drain_no_bubble", 32'(out_valid), 32'd1);
    end
    wait_drain();

    // random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) send_rand();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check("xfer_after_random", 32'(xfer_count), 32'(n_out));

    // asynchronous reset with items in flight
    out_ready = 1'b0;
    send_rand();
    send_rand();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_xfer_count", 32'(xfer_count), 32'd0);
    check("midrst_zero_flags", 32'(zero_flags), 32'd0);
    exp_q.delete();
    n_out = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_out_after_reset", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // saturation of the handshake counter
    for (int i = 0; i < 65540; i++) send_rand();
    wait_drain();
    check("xfer_saturated", 32'(xfer_count), 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
